// File: rtl/rf_writeback_ctrl_pkg.sv
// Shared LC-3b writeback types.
//   lc3b_word : 16-bit datapath word
//   lc3b_reg  : 3-bit architectural register index
//   wb_src_t  : which producer won the writeback port this cycle
package lc3b_types;

    localparam int unsigned WORD_W   = 16;
    localparam int unsigned REG_W    = 3;
    localparam int unsigned NUM_REGS = 8;
    localparam int unsigned STARVE_W = 4;

    typedef logic [WORD_W-1:0] lc3b_word;
    typedef logic [REG_W-1:0]  lc3b_reg;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_MEM  = 2'd2
    } wb_src_t;

endpackage

// File: rtl/rf_writeback_ctrl_if.sv
// Writeback request channels from the ALU and memory-load producers.
//   master : producer side (drives valid/dest/data, observes ready)
//   slave  : controller side (observes valid/dest/data, drives ready)
interface rf_writeback_ctrl_if;
    import lc3b_types::*;

    logic     alu_valid;
    logic     alu_ready;
    lc3b_reg  alu_dest;
    lc3b_word alu_data;
    logic     mem_valid;
    logic     mem_ready;
    lc3b_reg  mem_dest;
    lc3b_word mem_data;

    modport master (
        output alu_valid, alu_dest, alu_data,
        output mem_valid, mem_dest, mem_data,
        input  alu_ready, mem_ready
    );

    modport slave (
        input  alu_valid, alu_dest, alu_data,
        input  mem_valid, mem_dest, mem_data,
        output alu_ready, mem_ready
    );
endinterface

// File: rtl/rf_writeback_ctrl_scoreboard.sv
// Per-register busy scoreboard with bypass-aware hazard queries.
//   clk, rst           : clock, async active-high reset
//   issue_valid_i/dest : mark a register busy
//   flush_i            : clear all busy bits (same-cycle issue still sets)
//   rf_load_i/dest_i   : write on the regfile port this cycle; clears busy
//   src_a_i, src_b_i   : decode queries
//   busy_a_o, busy_b_o : combinational hazard flags
//   wb_orphan_o        : sticky flag, a write landed on a non-busy register
module rf_scoreboard
    import lc3b_types::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    issue_valid_i,
    input  lc3b_reg issue_dest_i,
    input  logic    flush_i,
    input  logic    rf_load_i,
    input  lc3b_reg rf_dest_i,
    input  lc3b_reg src_a_i,
    input  lc3b_reg src_b_i,
    output logic    busy_a_o,
    output logic    busy_b_o,
    output logic    wb_orphan_o
);

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic                orphan_q, orphan_d;

    // Clear before set so a same-cycle issue to the written register survives.
    always_comb begin
        busy_d = busy_q;
        if (flush_i) begin
            busy_d = '0;
        end else if (rf_load_i) begin
            busy_d[rf_dest_i] = 1'b0;
        end
        if (issue_valid_i) begin
            busy_d[issue_dest_i] = 1'b1;
        end
        orphan_d = orphan_q | (rf_load_i & ~busy_q[rf_dest_i]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q   <= '0;
            orphan_q <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            orphan_q <= orphan_d;
        end
    end

    // Register being written this cycle is bypassed by the regfile.
    assign busy_a_o    = busy_q[src_a_i] & ~(rf_load_i & (rf_dest_i == src_a_i));
    assign busy_b_o    = busy_q[src_b_i] & ~(rf_load_i & (rf_dest_i == src_b_i));
    assign wb_orphan_o = orphan_q;

endmodule

// File: rtl/rf_writeback_ctrl.sv
// LC-3b register-file writeback controller: arbitrates ALU/MEM writeback
// requests, registers the winner onto the regfile write port, and tracks
// per-register busy state for RAW hazard detection.
//   clk, rst         : clock, async active-high reset
//   wb               : ALU/MEM valid/ready request channels (slave side)
//   issue_valid/dest : issuing instruction marks its destination busy
//   flush            : clear scoreboard and starvation state
//   src_a/b, busy_a/b: hazard queries from decode
//   rf_load/dest/data: regfile write port (registered)
//   wb_orphan        : sticky write-to-non-busy-register indicator
module rf_writeback_ctrl
    import lc3b_types::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
)(
    input  logic                 clk,
    input  logic                 rst,
    rf_writeback_ctrl_if.slave   wb,
    input  logic                 issue_valid,
    input  lc3b_reg              issue_dest,
    input  logic                 flush,
    input  lc3b_reg              src_a,
    input  lc3b_reg              src_b,
    output logic                 busy_a,
    output logic                 busy_b,
    output logic                 rf_load,
    output lc3b_reg              rf_dest,
    output lc3b_word             rf_data,
    output logic                 wb_orphan
);

    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                force_mem;
    logic                alu_xfer, mem_xfer;
    wb_src_t             grant;

    logic     rf_load_q, rf_load_d;
    lc3b_reg  rf_dest_q, rf_dest_d;
    lc3b_word rf_data_q, rf_data_d;

    // Arbiter: ALU first unless MEM has waited STARVE_LIMIT cycles.
    assign force_mem    = (starve_q == STARVE_W'(STARVE_LIMIT));
    assign wb.alu_ready = ~force_mem;
    assign wb.mem_ready = force_mem | ~wb.alu_valid;
    assign alu_xfer     = wb.alu_valid & wb.alu_ready;
    assign mem_xfer     = wb.mem_valid & wb.mem_ready;

    always_comb begin
        grant = WB_NONE;
        if (alu_xfer) begin
            grant = WB_ALU;
        end else if (mem_xfer) begin
            grant = WB_MEM;
        end
    end

    // Starvation counter and output-stage next state.
    always_comb begin
        starve_d  = starve_q;
        rf_load_d = 1'b0;
        rf_dest_d = rf_dest_q;
        rf_data_d = rf_data_q;

        if (flush || !wb.mem_valid || mem_xfer) begin
            starve_d = '0;
        end else if (!force_mem) begin
            starve_d = starve_q + STARVE_W'(1);
        end

        case (grant)
            WB_ALU: begin
                rf_load_d = 1'b1;
                rf_dest_d = wb.alu_dest;
                rf_data_d = wb.alu_data;
            end
            WB_MEM: begin
                rf_load_d = 1'b1;
                rf_dest_d = wb.mem_dest;
                rf_data_d = wb.mem_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q  <= '0;
            rf_load_q <= 1'b0;
            rf_dest_q <= '0;
            rf_data_q <= '0;
        end else begin
            starve_q  <= starve_d;
            rf_load_q <= rf_load_d;
            rf_dest_q <= rf_dest_d;
            rf_data_q <= rf_data_d;
        end
    end

    assign rf_load = rf_load_q;
    assign rf_dest = rf_dest_q;
    assign rf_data = rf_data_q;

    rf_scoreboard u_scoreboard (
        .clk           (clk),
        .rst           (rst),
        .issue_valid_i (issue_valid),
        .issue_dest_i  (issue_dest),
        .flush_i       (flush),
        .rf_load_i     (rf_load_q),
        .rf_dest_i     (rf_dest_q),
        .src_a_i       (src_a),
        .src_b_i       (src_b),
        .busy_a_o      (busy_a),
        .busy_b_o      (busy_b),
        .wb_orphan_o   (wb_orphan)
    );

endmodule

// File: doc/rf_writeback_ctrl.md
Name: rf_writeback_ctrl

Overview:
- Write-side controller for the LC-3b register file.
- Arbitrates writeback requests from the ALU and memory-load producers over valid/ready channels.
- Registers the winning write onto the regfile write port (load/in/destt).
- Keeps a per-register busy scoreboard. Issue logic uses it to detect RAW hazards, with bypass semantics that match the regfile's same-cycle pass-through.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles a valid, un-granted mem request waits before it overrides ALU priority (1..15).
- NUM_REGS, 8: architectural registers; fixed by lc3b_reg width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- alu_valid  in  1  ALU writeback request
- alu_ready  out  1  ALU request accepted this cycle when high with alu_valid
- alu_dest  in  3  ALU destination register
- alu_data  in  16  ALU result
- mem_valid  in  1  memory-load writeback request
- mem_ready  out  1  mem request accepted this cycle when high with mem_valid
- mem_dest  in  3  load destination register
- mem_data  in  16  load data
- issue_valid  in  1  an instruction with a register destination issues this cycle
- issue_dest  in  3  its destination; marks that register busy
- flush  in  1  clear scoreboard and starvation state
- src_a, src_b  in  3  registers queried by decode
- busy_a, busy_b  out  1  combinational hazard flags for src_a/src_b
- rf_load  out  1  to regfile load
- rf_dest  out  3  to regfile destt
- rf_data  out  16  to regfile in
- wb_orphan  out  1  sticky: a write committed to a non-busy register

Behaviour:
- Reset (async, immediate): rf_load=0, rf_dest=0, rf_data=0, all busy bits 0, starve count 0, wb_orphan=0.
- Arbitration:
  - Fixed priority ALU over MEM, except when the starve count equals STARVE_LIMIT; then MEM wins.
  - alu_ready = ~force_mem.
  - mem_ready = force_mem | ~alu_valid.
  - force_mem = (starve_cnt == STARVE_LIMIT).
  - Ready never depends on its own channel's valid.
  - A transfer occurs on valid & ready. At most one transfer per cycle.
- Starvation counter:
  - Increments when mem_valid & ~mem_ready.
  - Clears on a mem transfer, when mem_valid is low, or on flush.
  - Saturates at STARVE_LIMIT.
- Output stage:
  - Latency 1. The cycle after a transfer, rf_load=1 with the accepted dest/data.
  - With no transfer, rf_load=0. rf_dest/rf_data hold their last values.
  - Back-to-back transfers produce rf_load high on consecutive cycles.
- Scoreboard:
  - busy[issue_dest] is set on issue_valid.
  - busy[rf_dest] is cleared in any cycle where rf_load=1.
  - Set and clear of the same register in one cycle: set wins.
  - flush clears all bits, but issue_valid in the same cycle still sets its bit.
  - flush does not cancel an accepted write already in the output stage.
- Hazard query: busy_a = busy[src_a] & ~(rf_load & rf_dest==src_a); busy_b likewise. A register being written this cycle reads as available, because the regfile bypasses it.
- wb_orphan sets when rf_load=1 and busy[rf_dest]=0 at that edge. It clears only on rst.
- Reset mid-operation: a pending output write is dropped (rf_load=0 immediately) and the scoreboard is wiped.

Decomposition:
- Package lc3b_types:
  - lc3b_word (16-bit) and lc3b_reg (3-bit), reused for all data/dest ports.
  - Add enum wb_src_t {WB_NONE, WB_ALU, WB_MEM} for the grant.
- Sub-module rf_scoreboard: busy vector, set/clear/flush priority, bypass-aware query ports, orphan detection.
- Arbiter, starvation counter and output register stay in the top.

Test Plan:
- ALU only, alu_valid=1 dest=3 data=16'h1234 for 1 cycle -> alu_ready=1; next cycle rf_load=1, rf_dest=3, rf_data=16'h1234; following cycle rf_load=0.
- ALU and MEM both valid continuously, STARVE_LIMIT=4 -> ALU granted cycles 0-3, mem_ready=1 in cycle 4 with alu_ready=0, counter back to 0, ALU granted again in cycle 5.
- issue_valid dest=5, then ALU write to 5 two cycles later; src_a=5 throughout -> busy_a=1 until the rf_load cycle, where busy_a=0 (bypass); busy[5]=0 afterwards.
- In the same cycle, issue_valid dest=2 while rf_load=1 rf_dest=2 -> busy[2] stays 1; wb_orphan stays 0.
- Busy bits set on R1 and R6, a write already accepted to R1, flush asserted -> all busy 0 except a same-cycle issue; the R1 write still appears on rf_load; wb_orphan=1.
- rst asserted asynchronously between accept and output edge -> rf_load drops to 0 at once, no write reaches the regfile, all busy bits 0.
